// File: rtl/game_over_banner_positioner.sv
// Game-over banner positioner: slides a scaled 32x32 banner down from above
// the screen to a rest position, updating only at frame boundaries, and
// produces the registered hit test and banner-local offsets for the bitmap.
// Optional blinking in the rest position is compiled in with GAMEOVER_BLINK_EN.
module game_over_banner_positioner #(
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int SCALE_SHIFT     = 2,
  parameter int TARGET_X        = 256,
  parameter int TARGET_Y        = 176,
  parameter int START_Y         = -128,
  parameter int SLIDE_STEP      = 4,
  parameter int BLINK_FRAMES    = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        gameOver,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        bannerSettled
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLIDE = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  // Screen-pixel extents and positions, all in 12-bit signed arithmetic so a
  // banner with a negative top edge clips naturally at row 0.
  localparam logic signed [11:0] W     = 12'(OBJECT_WIDTH_X << SCALE_SHIFT);
  localparam logic signed [11:0] H     = 12'(OBJECT_HEIGHT_Y << SCALE_SHIFT);
  localparam logic signed [11:0] TX    = 12'(TARGET_X);
  localparam logic signed [11:0] TY    = 12'(TARGET_Y);
  localparam logic signed [11:0] SY    = 12'(START_Y);
  localparam logic signed [11:0] STEP  = 12'(SLIDE_STEP);
  localparam logic signed [11:0] X_END = TX + W;

  logic [1:0]         state;
  logic signed [11:0] top_y;
  logic signed [11:0] step_y;
  logic               reach_target;
  logic               enter_show;
  logic               visible;

  assign step_y       = top_y + STEP;
  // Clamp test: any step landing on or past the rest row ends the slide.
  assign reach_target = (step_y >= TY);
  assign enter_show   = gameOver && (state == SLIDE) && startOfFrame && reach_target;
  assign bannerSettled = (state == SHOW);

  // Slide state machine; gameOver low always returns to IDLE at START_Y.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      top_y <= SY;
    end else if (!gameOver) begin
      state <= IDLE;
      top_y <= SY;
    end else begin
      case (state)
        // A frame pulse coinciding with the rise is not a step.
        IDLE: state <= SLIDE;
        SLIDE: begin
          if (startOfFrame) begin
            if (reach_target) begin
              top_y <= TY;
              state <= SHOW;
            end else begin
              top_y <= step_y;
            end
          end
        end
        SHOW:    state <= SHOW;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GAMEOVER_BLINK_EN
  localparam int CW = $clog2(BLINK_FRAMES + 1);

  logic [CW-1:0] blink_cnt;
  logic          blink_on;

  // Frame counter toggling banner visibility every BLINK_FRAMES frames in SHOW.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (enter_show) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (gameOver && (state == SHOW)) begin
      if (startOfFrame) begin
        if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end else begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end
  end

  // Blinking only applies at rest; the sliding banner is always drawn.
  assign visible = (state != SHOW) | blink_on;
`else
  assign visible = 1'b1;
`endif

  logic signed [11:0] px, py, dx, dy;
  logic               in_x, in_y, hit;

  assign px   = $signed({1'b0, pixelX});
  assign py   = $signed({1'b0, pixelY});
  assign dx   = px - TX;
  assign dy   = py - top_y;
  assign in_x = (px >= TX) && (px < X_END);
  assign in_y = (py >= top_y) && (py < top_y + H);
  assign hit  = (state != IDLE) && visible && in_x && in_y;

  // Registered hit test and scaled offsets; offsets are zero outside.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= hit;
      offsetX         <= hit ? 11'($unsigned(dx) >> SCALE_SHIFT) : 11'd0;
      offsetY         <= hit ? 11'($unsigned(dy) >> SCALE_SHIFT) : 11'd0;
    end
  end

endmodule

// File: doc/game_over_banner_positioner.md
Name: game_over_banner_positioner

Overview:
- Upstream stage of the 32x32 game-over banner bitmap: for each scanned pixel, decides whether the pixel falls inside the banner and produces the banner-local offsets.
- On game over, the banner slides down from above the screen to a fixed rest position and stays there, optionally blinking.
- Outputs connect directly to the bitmap's offsetX, offsetY and InsideRectangle inputs.
- Position changes only at frame boundaries, so the banner never tears mid-frame.

Parameters:
- OBJECT_WIDTH_X, 32, bitmap width in bitmap pixels.
- OBJECT_HEIGHT_Y, 32, bitmap height in bitmap pixels.
- SCALE_SHIFT, 2, on-screen magnification is 2^SCALE_SHIFT; at default, 32x32 is shown as 128x128.
- TARGET_X, 256, fixed left edge in screen pixels.
- TARGET_Y, 176, resting top edge in screen pixels.
- START_Y, -128, initial top edge, signed; fully above the screen.
- SLIDE_STEP, 4, screen pixels moved down per frame while sliding.
- BLINK_FRAMES, 16, frames per visible/hidden half-period; used only with blink compiled in.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- pixelX  in  11  current scan column.
- pixelY  in  11  current scan row.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- gameOver  in  1  level signal; high while the game-over screen is requested.
- offsetX  out  11  banner-local column, already divided by 2^SCALE_SHIFT.
- offsetY  out  11  banner-local row, already divided by 2^SCALE_SHIFT.
- InsideRectangle  out  1  high when the current pixel lies in the visible banner.
- bannerSettled  out  1  high once the banner has reached TARGET_Y.

Behaviour:
- Reset: asynchronous. All outputs go to 0, state to IDLE, topY to START_Y, frame counter to 0.
- topY: 12-bit signed register.
- Derived extents: W = OBJECT_WIDTH_X << SCALE_SHIFT; H = OBJECT_HEIGHT_Y << SCALE_SHIFT.
- State machine:
  - IDLE: InsideRectangle forced to 0 and topY held at START_Y. If gameOver=1, go to SLIDE.
  - SLIDE: on each startOfFrame, topY <= min(topY + SLIDE_STEP, TARGET_Y). When the updated value equals TARGET_Y, go to SHOW in the same cycle.
  - SHOW: topY frozen and bannerSettled=1.
  - Any state: gameOver=0 sends the FSM to IDLE on the next cycle. topY resets to START_Y and bannerSettled clears.
- Simultaneous events:
  - gameOver rise and startOfFrame in the same cycle: enter SLIDE with no step that cycle. The first step happens on the next startOfFrame.
  - gameOver fall during SLIDE: abort to IDLE; a later rise restarts from START_Y.
- Hit test, registered, 1-cycle latency from pixelX/pixelY:
  - inside = (state != IDLE) and visible and TARGET_X <= pixelX < TARGET_X+W and topY <= signed(pixelY) < topY+H.
  - Compare in 12-bit signed arithmetic, so a partly off-screen banner (negative topY) clips correctly at row 0.
- Offsets:
  - When inside: offsetX = (pixelX - TARGET_X) >> SCALE_SHIFT; offsetY = (pixelY - topY) >> SCALE_SHIFT. Range is 0..31 at default parameters.
  - When outside: both offsets are 0.
- visible is 1 unless the blink feature hides the banner.
- Edge rows and columns: column TARGET_X+W-1 is inside; column TARGET_X+W is outside. Rows follow the same rule.

Optional Feature:
- GAMEOVER_BLINK_EN defined:
  - In SHOW, a frame counter increments on each startOfFrame.
  - At BLINK_FRAMES it wraps to 0 and toggles visible.
  - Entering SHOW sets visible=1 and counter=0.
  - Leaving SHOW clears both.
- Not defined: the counter logic is absent and visible is constant 1.

Test Plan:
- Reset mid-SLIDE (topY=-64): assert resetN=0 -> all outputs 0 immediately, topY=-128; after release with gameOver=1, sliding restarts from -128.
- gameOver=1, run frames with default parameters -> topY goes -128, -124, ...; bannerSettled=1 after exactly 76 startOfFrame pulses with topY=176; topY stays 176 for 10 further frames.
- In SHOW, scan pixel (256,176) -> next cycle InsideRectangle=1, offsets (0,0). Pixel (383,303) -> offsets (31,31). Pixels (384,176) and (256,304) -> InsideRectangle=0, offsets 0.
- During SLIDE with topY=-8, scan pixel (300,0) -> InsideRectangle=1, offsetY=2, offsetX=11.
- gameOver dropped at topY=100 -> IDLE next cycle, InsideRectangle=0 for the whole frame; raising gameOver together with startOfFrame -> topY stays -128 until the following startOfFrame.
- With GAMEOVER_BLINK_EN, in SHOW: pixel (256,176) inside for 16 frames, outside for the next 16, inside again; without the macro it is always inside.
